// File: rtl/apb_master_if.sv
// Command/response port plus APB bus of the single-outstanding APB requester.
// The master modport is the requester's view; slave is the peripheral/client side.
interface apb_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB,
// one-cycle response pulse out, with a wait-state timeout that aborts the transfer.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input logic          pclk,
  input logic          preset_n,
  apb_master_if.master bus
);
  localparam int CNT_WIDTH = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_WAIT = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  // Only unregistered output: ready is a pure decode of the state register.
  assign bus.cmd_ready = (state == IDLE);

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= {ADDR_WIDTH{1'b0}};
      bus.pwdata    <= {DATA_WIDTH{1'b0}};
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.pwrite <= bus.cmd_write;
            bus.paddr  <= bus.cmd_addr;
            bus.pwdata <= bus.cmd_wdata;
            bus.psel   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          wait_cnt    <= '0;
          state       <= ACCESS;
        end
        ACCESS: begin
          // pready wins over the timeout on the last allowed cycle.
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_rdata <= bus.pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata;
            state         <= IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= {DATA_WIDTH{1'b0}};
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a simple valid/ready command port into APB SETUP/ACCESS transfers toward peripheral register blocks. It drives psel/penable/pwrite/paddr/pwdata, waits for pready, captures prdata and pslverr, and returns a one-cycle response pulse. A wait-state timeout aborts transfers to unresponsive peripherals.

## Interface
- ADDR_WIDTH, 8, paddr / cmd_addr width
- DATA_WIDTH, 8, pwdata / prdata / data width
- TIMEOUT, 16, max ACCESS cycles before abort (>= 1)

Clock and reset: one clock; reset is asynchronous and active-low (pclk, preset_n).

- pclk  input  1  clock, rising edge
- preset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; handshake = cmd_valid & cmd_ready at rising edge
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  output  1  pslverr captured, or timeout
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready / wait-state control
- pslverr  input  1  APB error, valid only with pready in ACCESS

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1, psel=0, penable=0. On handshake, latch cmd_write/addr/wdata into pwrite/paddr/pwdata; go to SETUP.
- SETUP: psel=1, penable=0 for exactly one cycle; go to ACCESS.
- ACCESS: psel=1, penable=1. Wait counter cleared on entry.
  - pready=1: rsp_valid=1 next cycle; rsp_err<=pslverr; rsp_rdata<=prdata for reads, 0 for writes; go to IDLE.
  - pready=0 and wait_cnt==TIMEOUT-1: abort with rsp_valid=1, rsp_err=1, rsp_rdata=0; go to IDLE.
  - pready=0 otherwise: wait_cnt+1, stay in ACCESS.
- pready=1 on the final allowed cycle completes normally; it does not time out.
- paddr/pwrite/pwdata are stable from SETUP through ACCESS and hold their last values in IDLE.
- cmd_* inputs are ignored outside IDLE.
- rsp_rdata/rsp_err hold their values until the next response.
- Counter width is $clog2(TIMEOUT)+1 bits; it does not wrap within a transfer.

## Timing
- Reset values:
  - state=IDLE, cmd_ready=1.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err all 0.
- All outputs except cmd_ready are registered. cmd_ready is decoded from state.
- Handshake at edge E0:
  - psel=1 after E0.
  - penable=1 after E1.
  - If pready=1 is sampled at E2, rsp_valid=1 after E2, for one cycle.
- Zero-wait transfer: 3 cycles from handshake to the next cmd_ready.
- Each pready=0 ACCESS cycle adds one cycle. ACCESS lasts at most TIMEOUT cycles.
- Back-to-back: in the cycle rsp_valid=1 the FSM is in IDLE. A command may be accepted in that cycle, and psel stays low for that one IDLE cycle.
- Async reset mid-transfer: psel/penable drop to 0 immediately, no rsp_valid is issued, and the transaction is lost.

## Test plan
- Reset, then write addr 0x04 data 0xA5 with pready tied 1:
  - psel=1 penable=0 for 1 cycle, then penable=1 for 1 cycle.
  - pwdata=0xA5, pwrite=1 during the transfer.
  - rsp_valid pulse with rsp_err=0, rsp_rdata=0x00.
- Read addr 0x04 while the slave returns prdata=0x5A after 3 wait states:
  - ACCESS lasts 4 cycles.
  - rsp_rdata=0x5A, rsp_err=0.
  - Handshake to next cmd_ready = 6 cycles.
- Read with pslverr=1 and pready=1 on the first ACCESS cycle: rsp_err=1, rsp_rdata=0x00 latched from prdata (0x00 by stimulus).
- pready held 0 with TIMEOUT=16:
  - Exactly 16 ACCESS cycles, then abort.
  - rsp_valid with rsp_err=1, rsp_rdata=0.
  - Repeat with pready=1 on the 16th cycle: normal completion with rsp_err=0.
- cmd_valid held high with alternating write/read commands:
  - One transfer per 3 cycles.
  - cmd_valid asserted during SETUP/ACCESS is not accepted.
  - paddr is stable through SETUP and ACCESS.
- Assert preset_n=0 during ACCESS: psel=penable=0 asynchronously, no rsp_valid, cmd_ready=1 after release.
